// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the UART receive buffer: default sizing and the
// stored entry layout.
package uart_rx_buf_pkg;

  localparam int UART_RX_DEPTH = 16;
  localparam int UART_RX_AW    = 4;
  localparam int UART_TO_TICKS = 40;

  // The frame-error bit sits above the data byte in each stored entry.
  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);

endpackage : uart_rx_buf_pkg

// File: rtl/uart_rx_buf_fifo.sv
// Generic show-ahead synchronous FIFO. The head word is read combinationally,
// and an explicit count register drives the full and empty flags.
module sync_fifo
  import uart_rx_buf_pkg::*;
#(
  parameter int WIDTH = RX_ENTRY_W,
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int AW    = UART_RX_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic [AW:0]      count_next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic             pop_ok_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is paired with a read.
  always_comb begin
    push_ok = push_i && (!full_o || pop_i);
    pop_ok  = pop_i && !empty_o;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o      = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign push_ok_o    = push_ok;
  assign pop_ok_o     = pop_ok;

endmodule : sync_fifo

// File: rtl/uart_rx_buf.sv
// UART receive buffer: queues completed bytes with their frame-error bit and
// adds sticky overrun, character timeout and a level/timeout interrupt.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int DEPTH    = UART_RX_DEPTH,
  parameter int AW       = UART_RX_AW,
  parameter int TO_TICKS = UART_TO_TICKS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_frame_err,
  input  logic        baud_tick,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_ferr,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count,
  input  logic [AW:0] trig_level,
  input  logic        intr_en,
  input  logic        ovr_clr,
  output logic        overrun,
  output logic        timeout,
  output logic        rx_intr
);

  localparam int TW = $clog2(TO_TICKS + 1);

  rx_entry_t   wr_entry;
  rx_entry_t   rd_entry;
  logic [AW:0] count_next;
  logic        push_ok, pop_ok;
  logic        activity;
  logic        drop;
  logic [AW:0] trig_eff;

  logic          overrun_q, overrun_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  logic          rx_intr_q, rx_intr_d;

  always_comb begin
    wr_entry      = '0;
    wr_entry.ferr = rx_frame_err;
    wr_entry.data = rx_data;
  end

  sync_fifo #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (rx_valid),
    .pop_i        (rd_en),
    .wdata_i      (wr_entry),
    .rdata_o      (rd_entry),
    .count_o      (count),
    .count_next_o (count_next),
    .full_o       (full),
    .empty_o      (empty),
    .push_ok_o    (push_ok),
    .pop_ok_o     (pop_ok)
  );

  assign activity = push_ok || pop_ok;
  assign drop     = rx_valid && full && !rd_en;
  assign trig_eff = (trig_level == '0) ? (AW+1)'(1) : trig_level;

  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    // A drop in the same cycle as a clear must not be lost.
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // The idle counter only runs while data is waiting and nothing moves.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (activity || empty) begin
      to_cnt_d  = '0;
      timeout_d = 1'b0;
    end else begin
      if (baud_tick && (to_cnt_q != TW'(TO_TICKS))) begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
      if (to_cnt_q == TW'(TO_TICKS)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_comb begin
    rx_intr_d = intr_en && ((count_next >= trig_eff) || timeout_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      rx_intr_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      rx_intr_q <= rx_intr_d;
    end
  end

  assign rd_data = rd_entry.data;
  assign rd_ferr = rd_entry.ferr;
  assign overrun = overrun_q;
  assign timeout = timeout_q;
  assign rx_intr = rx_intr_q;

endmodule : uart_rx_buf
